// File: rtl/keypad_pkg.sv
// keypad_pkg: shared keypad geometry, key index helpers and scanner state encoding
package keypad_pkg;
    localparam int NUM_ROWS  = 4;
    localparam int NUM_COLS  = 4;
    localparam int KEY_IDX_W = 4;
    localparam int ROW_W     = 2;
    typedef enum logic [1:0] {IDLE, SCAN, UPDATE} state_t;
    // scan bit index is col*4+row; reported key code is row*4+col
    function automatic logic [KEY_IDX_W-1:0] scan_to_code(input logic [KEY_IDX_W-1:0] bit_idx);
        return {bit_idx[ROW_W-1:0], bit_idx[KEY_IDX_W-1:ROW_W]};
    endfunction
endpackage

// File: rtl/keypad_scanner_if.sv
// keypad_scanner_if: keypad pins plus scanned key report toward the debouncer
interface keypad_scanner_if;
    import keypad_pkg::*;
    logic [NUM_ROWS-1:0]  row_in;
    logic [NUM_COLS-1:0]  col_out;
    logic                 key_raw;
    logic [KEY_IDX_W-1:0] key_code;
    logic                 multi_key;
    logic                 frame_done;
    modport master (input row_in, output col_out, key_raw, key_code, multi_key, frame_done);
    modport slave  (output row_in, input col_out, key_raw, key_code, multi_key, frame_done);
endinterface

// File: rtl/keypad_scanner_sync_2ff.sv
// sync_2ff: generic two-flop synchronizer with a configurable reset value
module sync_2ff #(
    parameter int               WIDTH   = 1,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);
    logic [WIDTH-1:0] meta;
    always_ff @(posedge clk) begin
        if (reset) begin
            meta <= RST_VAL;
            q    <= RST_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end
endmodule

// File: rtl/keypad_scanner.sv
// keypad_scanner: 4x4 column-scan keypad reader reporting single-key and multi-key frames
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int SETTLE_CYCLES = 1000
) (
    input logic              clk,
    input logic              reset,
    keypad_scanner_if.master kp
);
    localparam int CNT_W = $clog2(SETTLE_CYCLES);
    localparam logic [CNT_W-1:0] RELOAD = CNT_W'(SETTLE_CYCLES - 1);

    if (SETTLE_CYCLES < 3) begin : g_bad_settle
        $error("SETTLE_CYCLES must be at least 3");
    end

    state_t                        state, state_nxt;
    logic [1:0]                    col_idx, col_idx_nxt;
    logic [CNT_W-1:0]              cnt, cnt_nxt;
    logic [NUM_ROWS*NUM_COLS-1:0]  frame_bits, bits_nxt;
    logic [NUM_ROWS-1:0]           row_sync;
    logic                          key_raw_q, key_raw_nxt, multi_q, multi_nxt, done_q, done_nxt;
    logic [KEY_IDX_W-1:0]          code_q, code_nxt, enc;
    logic [4:0]                    pop;

    sync_2ff #(.WIDTH(NUM_ROWS), .RST_VAL(4'b1111)) u_sync (
        .clk   (clk),
        .reset (reset),
        .d     (kp.row_in),
        .q     (row_sync)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            col_idx    <= '0;
            cnt        <= '0;
            frame_bits <= '0;
            key_raw_q  <= 1'b0;
            multi_q    <= 1'b0;
            code_q     <= '0;
            done_q     <= 1'b0;
        end else begin
            state      <= state_nxt;
            col_idx    <= col_idx_nxt;
            cnt        <= cnt_nxt;
            frame_bits <= bits_nxt;
            key_raw_q  <= key_raw_nxt;
            multi_q    <= multi_nxt;
            code_q     <= code_nxt;
            done_q     <= done_nxt;
        end
    end

    always_comb begin
        pop = 5'($countones(frame_bits));
        enc = '0;
        for (int i = NUM_ROWS*NUM_COLS-1; i >= 0; i--)
            if (frame_bits[i]) enc = scan_to_code(KEY_IDX_W'(i));
        state_nxt   = state;
        col_idx_nxt = col_idx;
        cnt_nxt     = cnt;
        bits_nxt    = frame_bits;
        key_raw_nxt = key_raw_q;
        multi_nxt   = multi_q;
        code_nxt    = code_q;
        done_nxt    = 1'b0;
        case (state)
            IDLE: begin
                state_nxt   = SCAN;
                col_idx_nxt = '0;
                cnt_nxt     = RELOAD;
            end
            SCAN: begin
                cnt_nxt = cnt - 1'b1;
                if (cnt == '0) begin
                    bits_nxt[{col_idx, 2'b00} +: NUM_ROWS] = ~row_sync;
                    cnt_nxt     = RELOAD;
                    col_idx_nxt = col_idx + 1'b1;
                    state_nxt   = (col_idx == 2'd3) ? UPDATE : SCAN;
                end
            end
            UPDATE: begin
                state_nxt   = SCAN;
                bits_nxt    = '0;
                col_idx_nxt = '0;
                cnt_nxt     = RELOAD;
                done_nxt    = 1'b1;
                key_raw_nxt = (pop == 5'd1);
                multi_nxt   = (pop >= 5'd2);
                code_nxt    = (pop == 5'd1) ? enc : code_q;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign kp.col_out    = (state == SCAN) ? ~(4'b0001 << col_idx) : 4'b1111;
    assign kp.key_raw    = key_raw_q;
    assign kp.multi_key  = multi_q;
    assign kp.key_code   = code_q;
    assign kp.frame_done = done_q;
endmodule

// File: tb/tb_keypad_scanner.sv
// tb_keypad_scanner: scoreboard bench driving a modelled 4x4 key matrix into keypad_scanner
module tb_keypad_scanner;
    typedef struct packed {
        logic       raw;
        logic       multi;
        logic [3:0] code;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic [3:0][3:0] keys = '0;
    exp_t sb[$];
    int passed = 0;
    int total = 0;

    keypad_scanner_if kp();
    keypad_scanner #(.SETTLE_CYCLES(4)) dut (.clk(clk), .reset(reset), .kp(kp));

    always #5 clk = ~clk;

    always_comb begin
        kp.row_in = 4'b1111;
        for (int r = 0; r < 4; r++)
            kp.row_in[r] = ~|(keys[r] & ~kp.col_out);
    end

    task automatic wait_done();
        int n = 0;
        @(negedge clk);
        while (kp.frame_done !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (kp.frame_done !== 1'b1) begin
            total++;
            $display("FAIL frame_done_timeout: got %b want 1", kp.frame_done);
        end
    endtask

    task automatic check_frame(input string name);
        exp_t e, got;
        e = sb.pop_front();
        got = '{kp.key_raw, kp.multi_key, kp.key_code};
        total++;
        if (got !== e)
            $display("FAIL %s: got raw=%b multi=%b code=%0d want raw=%b multi=%b code=%0d",
                     name, got.raw, got.multi, got.code, e.raw, e.multi, e.code);
        else passed++;
    endtask

    task automatic test_reset();
        logic [3:0] ec;
        reset = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        total++;
        if ({kp.col_out, kp.key_raw, kp.key_code, kp.multi_key, kp.frame_done} !== 11'b1111_0_0000_0_0)
            $display("FAIL reset_state: got col=%b raw=%b code=%0d multi=%b done=%b want 1111/0/0/0/0",
                     kp.col_out, kp.key_raw, kp.key_code, kp.multi_key, kp.frame_done);
        else passed++;
        reset = 1'b0;
        sb.push_back('{1'b0, 1'b0, 4'd0});
        sb.push_back('{1'b0, 1'b0, 4'd0});
        for (int k = 0; k <= 35; k++) begin
            if (k > 0) @(negedge clk);
            ec = (k == 0 || k == 17 || k == 34) ? 4'b1111 : ~(4'b0001 << (((k - 1) % 17) / 4));
            total++;
            if (kp.col_out !== ec) $display("FAIL col_out_c%0d: got %b want %b", k, kp.col_out, ec);
            else passed++;
            total++;
            if (kp.frame_done !== (k == 18 || k == 35))
                $display("FAIL frame_done_c%0d: got %b want %b", k, kp.frame_done, (k == 18 || k == 35));
            else passed++;
            if (k == 18 || k == 35) check_frame("reset_frame");
        end
    endtask

    task automatic test_single_key();
        keys = '0;
        keys[2][1] = 1'b1;
        sb.push_back('{1'b1, 1'b0, 4'd9});
        wait_done();
        check_frame("single_press");
        keys = '0;
        repeat (6) @(negedge clk);
        total++;
        if (kp.key_code !== 4'd9 || kp.key_raw !== 1'b1)
            $display("FAIL single_hold: got raw=%b code=%0d want raw=1 code=9", kp.key_raw, kp.key_code);
        else passed++;
        sb.push_back('{1'b0, 1'b0, 4'd9});
        wait_done();
        check_frame("single_release");
    endtask

    task automatic test_chord();
        keys[0][0] = 1'b1;
        keys[3][3] = 1'b1;
        sb.push_back('{1'b0, 1'b1, 4'd9});
        wait_done();
        check_frame("chord");
        keys[0][0] = 1'b0;
        sb.push_back('{1'b1, 1'b0, 4'd15});
        wait_done();
        check_frame("chord_release");
    endtask

    task automatic test_mid_frame();
        keys = '0;
        sb.push_back('{1'b0, 1'b0, 4'd15});
        wait_done();
        check_frame("mid_idle");
        repeat (5) @(negedge clk);
        keys[1][0] = 1'b1;
        sb.push_back('{1'b0, 1'b0, 4'd15});
        sb.push_back('{1'b1, 1'b0, 4'd4});
        wait_done();
        check_frame("mid_late");
        wait_done();
        check_frame("mid_next");
    endtask

    task automatic test_boundary();
        keys = '0;
        keys[0][3] = 1'b1;
        sb.push_back('{1'b1, 1'b0, 4'd3});
        wait_done();
        check_frame("bound_03");
        keys = '0;
        keys[3][3] = 1'b1;
        sb.push_back('{1'b1, 1'b0, 4'd15});
        wait_done();
        check_frame("bound_33");
        keys = '0;
        for (int r = 0; r < 4; r++) keys[r][0] = 1'b1;
        sb.push_back('{1'b0, 1'b1, 4'd15});
        wait_done();
        check_frame("all_rows");
    endtask

    task automatic test_reset_mid_scan();
        keys = '0;
        keys[2][2] = 1'b1;
        sb.push_back('{1'b1, 1'b0, 4'd10});
        wait_done();
        check_frame("pre_reset");
        repeat (9) @(negedge clk);
        total++;
        if (kp.col_out !== 4'b1011) $display("FAIL col2_before_reset: got %b want 1011", kp.col_out);
        else passed++;
        reset = 1'b1;
        @(negedge clk);
        total++;
        if ({kp.col_out, kp.key_raw, kp.key_code, kp.multi_key, kp.frame_done} !== 11'b1111_0_0000_0_0)
            $display("FAIL midscan_clear: got col=%b raw=%b code=%0d multi=%b done=%b want 1111/0/0/0/0",
                     kp.col_out, kp.key_raw, kp.key_code, kp.multi_key, kp.frame_done);
        else passed++;
        @(negedge clk);
        reset = 1'b0;
        sb.push_back('{1'b1, 1'b0, 4'd10});
        for (int k = 1; k <= 18; k++) begin
            @(negedge clk);
            total++;
            if (kp.frame_done !== (k == 18))
                $display("FAIL restart_done_c%0d: got %b want %b", k, kp.frame_done, (k == 18));
            else passed++;
            if (k == 1) begin
                total++;
                if (kp.col_out !== 4'b1110) $display("FAIL restart_col0: got %b want 1110", kp.col_out);
                else passed++;
            end
        end
        check_frame("restart_frame");
    endtask

    initial begin
        test_reset();
        test_single_key();
        test_chord();
        test_mid_frame();
        test_boundary();
        test_reset_mid_scan();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
